// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer.
//   pc_state_e        : controller state encoding (IDLE, RUN, HALT)
//   DEFAULT_D         : default program-counter width
//   DEFAULT_RAS_DEPTH : default return-address-stack depth
package pc_seq_pkg;

    localparam int unsigned DEFAULT_D         = 12;
    localparam int unsigned DEFAULT_RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address LIFO used by the PC sequencer when PC_SEQ_RAS_EN is defined.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (empties the stack)
//   push, din    : write din on top (ignored when full)
//   pop          : drop top entry (ignored when empty)
//   dout         : current top entry, valid while !empty
//   full, empty  : occupancy flags
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned D         = DEFAULT_D,
    parameter int unsigned RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [D-1:0] din,
    output logic [D-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [D-1:0]  mem_q [RAS_DEPTH];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] top_cnt;
    logic [AW-1:0] top_idx;

    assign top_cnt = cnt_q - CW'(1);
    assign top_idx = top_cnt[AW-1:0];
    assign dout    = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (push && !full) begin
            cnt_q <= cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_q <= top_cnt;
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (!reset && push && !full) begin
            mem_q[cnt_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencing controller. Decodes control requests into
// zero-latency commands for an external program counter.
// Optional feature: define PC_SEQ_RAS_EN to add a hardware return-address stack.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : leave IDLE
//   stall, halt_req     : hold PC / stop execution (HALT is left only by reset)
//   br_taken            : skip next instruction (branch_en -> PC+2)
//   jmp_req, call_req   : jump / call to jmp_target
//   ret_req             : return from subroutine
//   jmp_target, prog_ctr: destination, current PC fed back
//   branch_en, jump_en  : PC commands (mutually exclusive)
//   target              : load value when jump_en=1
//   done                : high in HALT
//   ras_err             : sticky return-stack overflow/underflow
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned D         = DEFAULT_D,
    parameter int unsigned RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         halt_req,
    input  logic         br_taken,
    input  logic         jmp_req,
    input  logic         call_req,
    input  logic         ret_req,
    input  logic [D-1:0] jmp_target,
    input  logic [D-1:0] prog_ctr,
    output logic         branch_en,
    output logic         jump_en,
    output logic [D-1:0] target,
    output logic         done,
    output logic         ras_err
);

    if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two and at least 2");
    end

    pc_state_e state_q, state_d;

`ifdef PC_SEQ_RAS_EN
    logic         push, pop, full, empty, ras_err_q, ras_err_d;
    logic [D-1:0] ret_addr, top_addr;

    assign ret_addr = prog_ctr + D'(1);   // wraps modulo 2^D

    ras_stack #(
        .D         (D),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ret_addr),
        .dout  (top_addr),
        .full  (full),
        .empty (empty)
    );

    assign ras_err = ras_err_q;
`else
    assign ras_err = 1'b0;
`endif

    // Default is "hold": reload the current PC.
    always_comb begin
        state_d   = state_q;
        branch_en = 1'b0;
        jump_en   = 1'b1;
        target    = prog_ctr;
`ifdef PC_SEQ_RAS_EN
        push      = 1'b0;
        pop       = 1'b0;
        ras_err_d = ras_err_q;
`endif
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (stall) begin
                        state_d = RUN;   // hold, every request dropped
                    end else if (halt_req) begin
                        state_d = HALT;
                    end else begin
                        jump_en = 1'b0;
                        if (ret_req) begin
`ifdef PC_SEQ_RAS_EN
                            if (!empty) begin
                                pop     = 1'b1;
                                jump_en = 1'b1;
                                target  = top_addr;
                            end else begin
                                ras_err_d = 1'b1;   // underflow: plain increment
                            end
`endif
                        end else if (call_req) begin
                            jump_en = 1'b1;
                            target  = jmp_target;
`ifdef PC_SEQ_RAS_EN
                            if (full) ras_err_d = 1'b1;   // overflow: jump, drop push
                            else      push      = 1'b1;
`endif
                        end else if (jmp_req) begin
                            jump_en = 1'b1;
                            target  = jmp_target;
                        end else if (br_taken) begin
                            branch_en = 1'b1;
                        end
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PC_SEQ_RAS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ras_err_q <= 1'b0;
        end else begin
            ras_err_q <= ras_err_d;
        end
    end
`endif

    assign done = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int unsigned D = 12;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, stall, halt_req, br_taken, jmp_req, call_req, ret_req;
    logic [D-1:0] jmp_target, prog_ctr;
    logic         branch_en, jump_en, done, ras_err;
    logic [D-1:0] target;

    typedef struct {
        string        tag;
        logic         be;
        logic         je;
        logic [D-1:0] tgt;
        logic         dn;
        logic         er;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .D         (D),
        .RAS_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stall      (stall),
        .halt_req   (halt_req),
        .br_taken   (br_taken),
        .jmp_req    (jmp_req),
        .call_req   (call_req),
        .ret_req    (ret_req),
        .jmp_target (jmp_target),
        .prog_ctr   (prog_ctr),
        .branch_en  (branch_en),
        .jump_en    (jump_en),
        .target     (target),
        .done       (done),
        .ras_err    (ras_err)
    );

    // One cycle: drive after posedge, queue expectation, check at negedge.
    // req bits: {reset, start, stall, halt_req, br_taken, jmp_req, call_req, ret_req}
    task automatic step(input string tag, input logic [7:0] req, input logic [D-1:0] pc,
                        input logic [D-1:0] jt, input logic ebe, input logic eje,
                        input logic [D-1:0] etgt, input logic edn, input logic eer);
        exp_t e, got;
        logic [D+3:0] obs, want;
        @(posedge clk);
        #1;
        {reset, start, stall, halt_req, br_taken, jmp_req, call_req, ret_req} = req;
        prog_ctr   = pc;
        jmp_target = jt;
        e.tag = tag; e.be = ebe; e.je = eje; e.tgt = eje ? etgt : '0; e.dn = edn; e.er = eer;
        exp_q.push_back(e);
        @(negedge clk);
        got  = exp_q.pop_front();
        obs  = {branch_en, jump_en, (got.je ? target : {D{1'b0}}), done, ras_err};
        want = {got.be, got.je, got.tgt, got.dn, got.er};
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s: got be=%b je=%b tgt=%h done=%b err=%b want be=%b je=%b tgt=%h done=%b err=%b",
                   got.tag, branch_en, jump_en, target, done, ras_err,
                   got.be, got.je, got.tgt, got.dn, got.er);
        end
    endtask

    initial begin
        logic [D-1:0] a;
        {reset, start, stall, halt_req, br_taken, jmp_req, call_req, ret_req} = 8'h80;
        prog_ctr = 12'h010; jmp_target = '0;

        step("reset_hold", 8'h80, 12'h010, 12'h000, 0, 1, 12'h010, 0, 0);
        step("idle_start", 8'h40, 12'h010, 12'h000, 0, 1, 12'h010, 0, 0);
        step("run_incr",   8'h00, 12'h011, 12'h000, 0, 0, 12'h000, 0, 0);
        step("call",       8'h02, 12'h020, 12'h100, 0, 1, 12'h100, 0, 0);
        step("ret",        8'h01, 12'h100, 12'h000, 0, RAS, 12'h021, 0, 0);
        step("br_vs_jmp",  8'h0C, 12'h022, 12'h3FF, 0, 1, 12'h3FF, 0, 0);
        step("branch",     8'h08, 12'h3FF, 12'h000, 1, 0, 12'h000, 0, 0);

        // Five nested calls into a four-deep stack.
        for (int i = 0; i < 5; i++) begin
            a = 12'h300 + 12'(i);
            step("nest_call", 8'h02, 12'h200 + 12'(i), a, 0, 1, a, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            a = 12'h204 - 12'(i);
            step("nest_ret", 8'h01, 12'h400, 12'h000, 0, RAS, a, 0, RAS);
        end
        step("ret_under",  8'h01, 12'h400, 12'h000, 0, 0, 12'h000, 0, RAS);
        step("err_sticky", 8'h00, 12'h401, 12'h000, 0, 0, 12'h000, 0, RAS);

        // Return address wraps from all-ones.
        step("call_wrap",  8'h02, 12'hFFF, 12'h050, 0, 1, 12'h050, 0, RAS);
        step("ret_wrap",   8'h01, 12'h050, 12'h000, 0, RAS, 12'h000, 0, RAS);

        // Reset mid-RUN discards stack contents and same-cycle ret.
        step("pre_call",   8'h02, 12'h030, 12'h060, 0, 1, 12'h060, 0, RAS);
        step("rst_run",    8'h81, 12'h060, 12'h000, 0, 1, 12'h060, 0, RAS);
        step("restart",    8'h40, 12'h061, 12'h000, 0, 1, 12'h061, 0, 0);
        step("stall_call", 8'h22, 12'h062, 12'h0A0, 0, 1, 12'h062, 0, 0);
        step("ret_empty",  8'h01, 12'h062, 12'h000, 0, 0, 12'h000, 0, 0);
        step("err_set",    8'h00, 12'h063, 12'h000, 0, 0, 12'h000, 0, RAS);

        // Stall beats halt and jump; then halt alone.
        step("stall_halt", 8'h34, 12'h064, 12'h123, 0, 1, 12'h064, 0, RAS);
        step("still_run",  8'h00, 12'h064, 12'h000, 0, 0, 12'h000, 0, RAS);
        step("halt",       8'h10, 12'h065, 12'h000, 0, 1, 12'h065, 0, RAS);
        step("halt_start", 8'h40, 12'h065, 12'h000, 0, 1, 12'h065, 1, RAS);
        step("halt_jmp",   8'h06, 12'h065, 12'h200, 0, 1, 12'h065, 1, RAS);
        step("halt_rst",   8'h80, 12'h065, 12'h000, 0, 1, 12'h065, 1, RAS);
        step("post_rst",   8'h00, 12'h066, 12'h000, 0, 1, 12'h066, 0, 0);

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter D, default 12, program-counter width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, return-stack entries (power of two, >=2).
REQ-003 clk  input  1  single clock, all state on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  leave IDLE and begin execution.
REQ-006 stall  input  1  hold PC this cycle.
REQ-007 halt_req  input  1  stop execution (sticky).
REQ-008 br_taken  input  1  conditional branch taken (skip next instruction, PC+2).
REQ-009 jmp_req  input  1  absolute jump to jmp_target.
REQ-010 call_req  input  1  subroutine call to jmp_target.
REQ-011 ret_req  input  1  return from subroutine.
REQ-012 jmp_target  input  D  jump/call destination.
REQ-013 prog_ctr  input  D  current PC value, fed back from the program counter.
REQ-014 branch_en  output  1  PC+2 command to the program counter.
REQ-015 jump_en  output  1  load-target command to the program counter.
REQ-016 target  output  D  value loaded when jump_en=1.
REQ-017 done  output  1  high while in HALT.
REQ-018 ras_err  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-019 FSM states IDLE, RUN, HALT; IDLE->RUN on start; RUN->HALT on halt_req (not stalled); HALT exits only via reset.
REQ-020 branch_en, jump_en and target are combinational from state and same-cycle inputs; the PC acts on them at the next posedge (zero-cycle controller latency).
REQ-021 Hold = jump_en=1, target=prog_ctr; used in IDLE, HALT, RUN with stall, and RUN with halt_req.
REQ-022 RUN priority, highest first: stall, halt_req, ret_req, call_req, jmp_req, br_taken, else plain increment (branch_en=0, jump_en=0).
REQ-023 jmp_req: jump_en=1, target=jmp_target. br_taken: branch_en=1.
REQ-024 branch_en and jump_en are never high in the same cycle.
REQ-025 Lower-priority requests in a cycle are dropped, not queued; stall suppresses all stack pushes/pops.
REQ-026 Return address = prog_ctr+1, modulo 2^D (wrap from all-ones to 0).
REQ-027 done=1 iff state==HALT.
REQ-028 Stack updates, state and ras_err change only on posedge.

Reset
REQ-029 On reset: state=IDLE, stack empty, ras_err=0; outputs become hold (jump_en=1, target=prog_ctr, branch_en=0, done=0).
REQ-030 Reset mid-RUN or in HALT discards all stack contents and any same-cycle request.

Configuration
REQ-031 PC_SEQ_RAS_EN defined: call_req pushes the return address and jumps to jmp_target; ret_req pops, with jump_en=1 and target=popped value.
REQ-032 With PC_SEQ_RAS_EN, call with stack full: jump taken, push dropped, ras_err set. ret with stack empty: treated as plain increment, ras_err set.
REQ-033 PC_SEQ_RAS_EN undefined: no stack storage; call_req behaves as jmp_req, ret_req is ignored (plain increment), ras_err tied 0.

Structure
REQ-034 Package pc_seq_pkg holds the state enum typedef (IDLE/RUN/HALT) and the default D and RAS_DEPTH constants.
REQ-035 Sub-module ras_stack (LIFO: push, pop, din, dout, full, empty; parameters D, RAS_DEPTH) is instantiated only under PC_SEQ_RAS_EN.

Verification
REQ-036 Reset, then start with prog_ctr=0x010 and no requests -> IDLE holds (jump_en=1, target=0x010); next cycle increment (both enables 0).
REQ-037 RUN, prog_ctr=0x020, call_req with jmp_target=0x100 -> jump_en, target=0x100; later ret_req -> target=0x021.
REQ-038 Five nested calls with RAS_DEPTH=4 -> fifth jump taken, ras_err=1; four rets return LIFO; fifth ret -> increment, ras_err stays 1.
REQ-039 Same cycle: stall, halt_req, jmp_req -> hold, stays RUN; next cycle halt_req alone -> hold, done=1, start ignored thereafter.
REQ-040 Same cycle: br_taken and jmp_req (target 0x3FF) -> jump_en only; call at prog_ctr=0xFFF -> pushed 0x000; reset during RUN -> IDLE, subsequent ret -> increment, ras_err=1.
